// File: rtl/booth_pkg.sv
// Shared encodings for the radix-2 Booth sequencing controller.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ARITH = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  // {Q0, Q(-1)} pairs that need an accumulator update
  localparam logic [1:0] PAIR_SUB = 2'b10;
  localparam logic [1:0] PAIR_ADD = 2'b01;

endpackage

// File: rtl/booth_iter_counter.sv
// Loadable iteration down-counter with a last-iteration flag.
// flush zeroes the count and wins over load/dec; dec saturates at zero.
module booth_iter_counter #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 dec,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 is_last
);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear)                   cnt <= '0;
    else if (flush)               cnt <= '0;
    else if (load)                cnt <= CNT_WIDTH'(DATA_WIDTH);
    else if (dec && (cnt != '0))  cnt <= cnt - 1'b1;
  end

  assign count_out = cnt;
  assign is_last   = (cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/booth_control_unit.sv
// Radix-2 Booth multiplier sequencer: Moore strobes from registered state.
// Optional abort input enabled by defining BOOTH_ABORT_EN.
module booth_control_unit
  import booth_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
`ifdef BOOTH_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 q0,
  input  logic                 q_m1,
  output logic                 ld_m,
  output logic                 ld_q,
  output logic                 clr_acc,
  output logic                 clr_qm1,
  output logic                 ld_acc,
  output logic                 alu_sub,
  output logic                 shift_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] iter_cnt
);

  state_e     state, state_nxt;
  logic       abort_hit;
  logic       is_last;
  logic [1:0] pair;

  assign pair = {q0, q_m1};

`ifdef BOOTH_ABORT_EN
  assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  booth_iter_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_iter_cnt (
    .clk       (clk),
    .clear     (clear),
    .load      (state == LOAD),
    .dec       (state == SHIFT),
    .flush     (abort_hit),
    .count_out (iter_cnt),
    .is_last   (is_last)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      alu_sub <= 1'b0;
    end else begin
      state <= state_nxt;
      // operation is latched in EVAL so ARITH needs no input path
      if ((state == EVAL) && !abort_hit) begin
        if (pair == PAIR_SUB)      alu_sub <= 1'b1;
        else if (pair == PAIR_ADD) alu_sub <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = EVAL;
      EVAL:    state_nxt = ((pair == PAIR_SUB) || (pair == PAIR_ADD)) ? ARITH : SHIFT;
      ARITH:   state_nxt = SHIFT;
      SHIFT:   state_nxt = is_last ? DONE : EVAL;
      // a start held through completion chains straight into the next load
      DONE:    state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_comb begin
    ld_m     = 1'b0;
    ld_q     = 1'b0;
    clr_acc  = 1'b0;
    clr_qm1  = 1'b0;
    ld_acc   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        ld_m    = 1'b1;
        ld_q    = 1'b1;
        clr_acc = 1'b1;
        clr_qm1 = 1'b1;
        busy    = 1'b1;
      end
      EVAL:  busy = 1'b1;
      ARITH: begin
        ld_acc = 1'b1;
        busy   = 1'b1;
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
